// File: rtl/din_debounce_edge.sv
// din_debounce_edge
// Input conditioner for the ones-counting edge FSM. It synchronises a raw
// asynchronous input, debounces it, and emits a clean level plus single-cycle
// rise/fall pulses. rise_pulse feeds the downstream FSM's din, so each physical
// press is counted exactly once.
//
// Ports:
//   clk         in   1  single clock, all logic on posedge
//   reset       in   1  asynchronous active-high reset, clears all state
//   raw_in      in   1  asynchronous raw input (switch/pin)
//   enable      in   1  1 = filter active, 0 = freeze accepted level and abort checks
//   level_out   out  1  debounced level
//   rise_pulse  out  1  one-cycle pulse when level_out goes 0->1
//   fall_pulse  out  1  one-cycle pulse when level_out goes 1->0
//   glitch_cnt  out  8  saturating count of rejected glitches
//                       (present only when GLITCH_COUNT_EN is defined)
//
// Optional feature macro: GLITCH_COUNT_EN
//
// Parameters:
//   SYNC_STAGES      synchroniser depth, legal >= 2
//   DEBOUNCE_CYCLES  consecutive equal samples needed to accept a change, legal >= 1

module din_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  input  logic       enable,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse
`ifdef GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic [1:0]             state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   level_d, rise_d, fall_d;
`ifdef GLITCH_COUNT_EN
  logic                   glitch_evt;
`endif

  // Synchroniser runs regardless of enable so that re-enabling never acts on
  // a stale, possibly metastable sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_in};
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Debounce FSM next-state logic. The sample that moves a STABLE state into
  // its CHK state already counts as the first agreeing sample, which is why
  // the check completes when cnt reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef GLITCH_COUNT_EN
    glitch_evt = 1'b0;
`endif
    case (state)
      STABLE_LO: begin
        cnt_d = '0;
        if (enable && sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!enable) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (!sync_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
`ifdef GLITCH_COUNT_EN
          glitch_evt = 1'b1;
`endif
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (enable && !sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (!enable) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (sync_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
`ifdef GLITCH_COUNT_EN
          glitch_evt = 1'b1;
`endif
        end else if (cnt == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // All FSM outputs are registered so downstream logic sees glitch-free pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

`ifdef GLITCH_COUNT_EN
  // Rejected-glitch counter saturates rather than wrapping so a noisy pin
  // never appears clean after overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_evt && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_din_debounce_edge.sv
// tb_din_debounce_edge
// Self-checking bench for din_debounce_edge with default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4). A vector table covers rise, fall, short
// glitches and enable aborts; hand-written sequences cover asynchronous reset
// mid-cycle and glitch-counter saturation (when GLITCH_COUNT_EN is defined).

module tb_din_debounce_edge;

  typedef struct {
    logic raw;
    logic en;
    logic lvl;
    logic rise;
    logic fall;
  } vec_t;

  logic clk;
  logic reset;
  logic raw_in;
  logic enable;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
`ifdef GLITCH_COUNT_EN
  logic [7:0] glitch_cnt;
`endif

  int compared;
  int mismatched;
  vec_t vecs[$];

  din_debounce_edge #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .enable(enable),
    .level_out(level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`ifdef GLITCH_COUNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic raw, input logic en);
    raw_in = raw;
    enable = en;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic raw, input logic en, input logic lvl,
                        input logic rise, input logic fall);
    vec_t v;
    v.raw  = raw;
    v.en   = en;
    v.lvl  = lvl;
    v.rise = rise;
    v.fall = fall;
    vecs.push_back(v);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " level"}, int'(level_out), 0);
    checkOutput({tag, " rise"}, int'(rise_pulse), 0);
    checkOutput({tag, " fall"}, int'(fall_pulse), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    applyStimulus(1'b0, 1'b1);

    // Vector table: inputs are applied before an edge, outputs checked 1 time
    // unit after it.
    // rise: sync takes 2 edges, then 4 agreeing samples
    for (int i = 0; i < 5; i++) addVec(1, 1, 0, 0, 0);
    addVec(1, 1, 1, 1, 0);
    addVec(1, 1, 1, 0, 0);
    // fall
    for (int i = 0; i < 5; i++) addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 1);
    addVec(0, 1, 0, 0, 0);
    // two-cycle glitch, rejected
    addVec(1, 1, 0, 0, 0);
    addVec(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) addVec(0, 1, 0, 0, 0);
    // rising check aborted by enable=0 for 3 cycles, then restarts
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 0);
    addVec(1, 1, 1, 1, 0);
    addVec(1, 1, 1, 0, 0);
    // level frozen while disabled, falls 4 samples after re-enable
    for (int i = 0; i < 6; i++) addVec(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 1);
    addVec(0, 1, 0, 0, 0);

    // Reset state
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("reset");
`ifdef GLITCH_COUNT_EN
    checkOutput("reset glitch_cnt", int'(glitch_cnt), 0);
`endif
    stepCycle();
    stepCycle();
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].raw, vecs[i].en);
      stepCycle();
      checkOutput($sformatf("v%0d level", i), int'(level_out), int'(vecs[i].lvl));
      checkOutput($sformatf("v%0d rise", i), int'(rise_pulse), int'(vecs[i].rise));
      checkOutput($sformatf("v%0d fall", i), int'(fall_pulse), int'(vecs[i].fall));
    end
`ifdef GLITCH_COUNT_EN
    // Only the two-cycle glitch counts; enable aborts do not.
    checkOutput("table glitch_cnt", int'(glitch_cnt), 1);
`endif

    // Asynchronous reset mid-cycle while rise_pulse is high
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) stepCycle();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("pre-reset rise", int'(rise_pulse), 1);
    checkOutput("pre-reset level", int'(level_out), 1);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async reset");
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkAllZero($sformatf("post-reset c%0d", i));
    end
`ifdef GLITCH_COUNT_EN
    checkOutput("post-reset glitch_cnt", int'(glitch_cnt), 0);
`endif

    // 300 two-cycle glitches: level never moves; counter saturates at 255.
    // Each glitch is registered on the first edge of the following iteration.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, 1'b1);
      stepCycle();
      stepCycle();
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      stepCycle();
      if ((k % 50) == 0) checkAllZero($sformatf("glitch k%0d", k));
`ifdef GLITCH_COUNT_EN
      if (k == 99) checkOutput("glitch_cnt after 100", int'(glitch_cnt), 99);
`endif
    end
    for (int i = 0; i < 4; i++) stepCycle();
    checkAllZero("glitch end");
`ifdef GLITCH_COUNT_EN
    checkOutput("glitch_cnt saturated", int'(glitch_cnt), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
